// File: rtl/uart_rx_ctrl_if.sv
// Receive FIFO read port between the UART RX controller (master) and the
// bus-side reader (slave).
interface uart_rx_ctrl_if;
  logic [7:0] o_rd_data;
  logic       o_rd_valid;
  logic       i_rd_ready;

  modport master (output o_rd_data, output o_rd_valid, input i_rd_ready);
  modport slave  (input o_rd_data, input o_rd_valid, output i_rd_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, mid-bit strobes, core result
// capture into a small FIFO, and error/overflow statistics.
//
// state | meaning
// IDLE  | waiting for a falling edge on the line while enabled
// HALF  | counting to the middle of the start bit
// BIT   | one strobe per bit period for data/parity/stop bits
// WAIT  | short window for the core to report its result
module uart_rx_ctrl #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable_n,
  input  logic [DIV_W-1:0] i_baud_div,
  input  logic [1:0]       i_parity,
  input  logic             i_rx_line,
  output logic             o_clk_rx,
  output logic             o_rx_data,
  output logic [1:0]       o_parity,
  output logic             o_enable_n,
  output logic             o_int_clrxn,
  input  logic             i_core_int,
  input  logic [7:0]       i_core_data,
  input  logic             i_core_err,
  uart_rx_ctrl_if.master   rd,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_err_cnt,
  input  logic             i_clr_stat
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, HALF, BIT, WAIT} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bitn_q, bitn_d;
  logic [1:0]       par_q, par_d;
  logic             strobe_q, strobe_d;
  logic             rx_q, en_n_q, int_prev_q, clrxn_q;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;

  logic [DIV_W-1:0] div_in;
  logic [3:0]       nb;
  logic             err_evt, push_req, push, pop, full, ovf_evt;

  assign div_in = (i_baud_div < DIV_W'(4)) ? DIV_W'(4) : i_baud_div;
  // Parity modes 10 and 11 have no parity bit: 8 data + stop.
  assign nb     = par_q[1] ? 4'd9 : 4'd10;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= DIV_W'(4);
      bitn_q   <= '0;
      par_q    <= 2'b10;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bitn_q   <= bitn_d;
      par_q    <= par_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bitn_d   = bitn_q;
    par_d    = par_q;
    strobe_d = 1'b0;
    err_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        // rx_q is last cycle's line, so a start needs the line seen high first.
        if (!i_enable_n && rx_q && !i_rx_line) begin
          div_d   = div_in;
          par_d   = i_parity;
          cnt_d   = (div_in >> 1) - DIV_W'(1);
          state_d = HALF;
        end
      end
      HALF: begin
        if (i_enable_n)           state_d = IDLE;
        else if (cnt_q != '0)     cnt_d   = cnt_q - DIV_W'(1);
        else if (!i_rx_line) begin
          strobe_d = 1'b1;
          bitn_d   = '0;
          cnt_d    = div_q - DIV_W'(1);
          state_d  = BIT;
        end else                  state_d = IDLE;
      end
      BIT: begin
        if (i_enable_n)           state_d = IDLE;
        else if (cnt_q != '0)     cnt_d   = cnt_q - DIV_W'(1);
        else begin
          strobe_d = 1'b1;
          bitn_d   = bitn_q + 4'd1;
          cnt_d    = div_q - DIV_W'(1);
          if (bitn_q + 4'd1 == nb) begin
            cnt_d   = DIV_W'(3);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (i_enable_n)           state_d = IDLE;
        else if (cnt_q != '0)     cnt_d   = cnt_q - DIV_W'(1);
        else begin
          err_evt = i_core_err;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_req = i_core_int & ~int_prev_q;
  assign pop      = (count_q != '0) & rd.i_rd_ready;
  assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
  assign push     = push_req & (~full | pop);
  assign ovf_evt  = push_req & full & ~pop;

  assign ovf_d     = i_clr_stat ? 1'b0 : (ovf_q | ovf_evt);
  assign err_cnt_d = i_clr_stat ? '0 :
                     (err_evt && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_q       <= 1'b1;
      en_n_q     <= 1'b1;
      int_prev_q <= 1'b0;
      clrxn_q    <= 1'b1;
      ovf_q      <= 1'b0;
      err_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rx_q       <= i_rx_line;
      en_n_q     <= i_enable_n;
      int_prev_q <= i_core_int;
      clrxn_q    <= ~push_req;
      ovf_q      <= ovf_d;
      err_cnt_q  <= err_cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= i_core_data;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_clk_rx      = strobe_q;
  assign o_rx_data     = rx_q;
  assign o_parity      = par_q;
  assign o_enable_n    = en_n_q;
  assign o_int_clrxn   = clrxn_q;
  assign o_ovf         = ovf_q;
  assign o_err_cnt     = err_cnt_q;
  assign rd.o_rd_data  = mem_q[rd_ptr_q];
  assign rd.o_rd_valid = (count_q != '0);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural receive core model.
module tb_uart_rx_ctrl;
  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_enable_n = 1'b0, i_rx_line = 1'b0;
  logic        i_core_int = 1'b0, i_core_err = 1'b0, i_clr_stat = 1'b0;
  logic [15:0] i_baud_div = 16'd16;
  logic [1:0]  i_parity = 2'b10;
  logic [7:0]  i_core_data = 8'h00;
  logic        o_clk_rx, o_rx_data, o_enable_n, o_int_clrxn, o_ovf;
  logic [1:0]  o_parity;
  logic [7:0]  o_err_cnt;

  uart_rx_ctrl_if rd_if ();

  uart_rx_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable_n(i_enable_n),
    .i_baud_div(i_baud_div), .i_parity(i_parity), .i_rx_line(i_rx_line),
    .o_clk_rx(o_clk_rx), .o_rx_data(o_rx_data), .o_parity(o_parity),
    .o_enable_n(o_enable_n), .o_int_clrxn(o_int_clrxn),
    .i_core_int(i_core_int), .i_core_data(i_core_data), .i_core_err(i_core_err),
    .rd(rd_if), .o_ovf(o_ovf), .o_err_cnt(o_err_cnt), .i_clr_stat(i_clr_stat)
  );

  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0;
  int cyc = 0;
  int strobes[$];
  int clr_pulses = 0;
  int fall_cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Core model: samples o_rx_data on each strobe, reports byte or error.
  logic [10:0] sh;
  int          idx = 0, nbt;
  logic        ok;
  always @(negedge i_clk) begin
    if (o_clk_rx) strobes.push_back(cyc);
    if (!o_int_clrxn) clr_pulses++;
    if (!i_rst_n || o_enable_n) begin
      idx = 0; i_core_int = 1'b0; i_core_err = 1'b0;
    end else begin
      if (!o_int_clrxn) i_core_int = 1'b0;
      if (o_clk_rx) begin
        if (idx == 0) i_core_err = 1'b0;
        sh[idx] = o_rx_data;
        idx++;
        nbt = o_parity[1] ? 10 : 11;
        if (idx == nbt) begin
          ok = sh[nbt-1] & ~sh[0];
          if (!o_parity[1]) ok = ok & ((^sh[9:1]) == o_parity[0]);
          if (ok) begin i_core_data = sh[8:1]; i_core_int = 1'b1; end
          else i_core_err = 1'b1;
          idx = 0;
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pop_check(input string nm, input int exp);
    check({nm, "_valid"}, rd_if.o_rd_valid, 1);
    check({nm, "_data"}, rd_if.o_rd_data, exp);
    rd_if.i_rd_ready = 1'b1;
    @(negedge i_clk);
    rd_if.i_rd_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_clk_rx"}, o_clk_rx, 0);
    check({tag, "_rx_data"}, o_rx_data, 1);
    check({tag, "_parity"}, o_parity, 2);
    check({tag, "_enable_n"}, o_enable_n, 1);
    check({tag, "_int_clrxn"}, o_int_clrxn, 1);
    check({tag, "_rd_valid"}, rd_if.o_rd_valid, 0);
    check({tag, "_rd_data"}, rd_if.o_rd_data, 0);
    check({tag, "_ovf"}, o_ovf, 0);
    check({tag, "_err_cnt"}, o_err_cnt, 0);
  endtask

  // Drives a whole frame; div_eff is the bit period the line is held for.
  task automatic send_frame(input logic [7:0] d, input int div_in, input int div_eff,
                            input logic [1:0] par, input bit bad_par);
    logic pbit;
    pbit = ^d;
    if (par == 2'b01) pbit = ~pbit;
    if (bad_par) pbit = ~pbit;
    i_baud_div = 16'(div_in);
    i_parity   = par;
    strobes.delete();
    @(negedge i_clk);
    i_rx_line = 1'b0;
    fall_cyc  = cyc + 1;
    @(negedge i_clk);
    i_baud_div = 16'd3;
    i_parity   = ~par;
    repeat (div_eff - 1) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_rx_line = d[i];
      repeat (div_eff) @(negedge i_clk);
    end
    if (!par[1]) begin
      i_rx_line = pbit;
      repeat (div_eff) @(negedge i_clk);
    end
    i_rx_line = 1'b1;
    repeat (div_eff + 8) @(negedge i_clk);
  endtask

  typedef struct {
    logic [7:0] data;
    int         div_in;
    int         div_eff;
    logic [1:0] par;
    bit         bad_par;
    int         exp_strobes;
    bit         exp_push;
    int         exp_err;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, first_bad;
    vecs[0] = '{8'hA5, 16, 16, 2'b10, 1'b0, 10, 1'b1, 0};
    vecs[1] = '{8'h3C, 16, 16, 2'b00, 1'b1, 11, 1'b0, 1};
    vecs[2] = '{8'h3C, 16, 16, 2'b00, 1'b0, 11, 1'b1, 1};
    vecs[3] = '{8'h96,  2,  4, 2'b10, 1'b0, 10, 1'b1, 1};
    vecs[4] = '{8'h7E, 16, 16, 2'b01, 1'b0, 11, 1'b1, 1};
    vecs[5] = '{8'hC3,  8,  8, 2'b11, 1'b0, 10, 1'b1, 1};
    vecs[6] = '{8'h81, 16, 16, 2'b01, 1'b1, 11, 1'b0, 2};
    rd_if.i_rd_ready = 1'b0;

    repeat (3) @(negedge i_clk);
    check_reset_vals("reset");
    i_rx_line = 1'b1;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);

    for (int v = 0; v < NV; v++) begin
      c0 = clr_pulses;
      send_frame(vecs[v].data, vecs[v].div_in, vecs[v].div_eff, vecs[v].par, vecs[v].bad_par);
      check("strobe_cnt", strobes.size(), vecs[v].exp_strobes);
      first_bad = -1;
      for (int n = 0; n < strobes.size(); n++)
        if (first_bad < 0 &&
            strobes[n] != fall_cyc + vecs[v].div_eff / 2 + n * vecs[v].div_eff)
          first_bad = n;
      check("strobe_time_first_bad_idx", first_bad, -1);
      check("clr_pulses", clr_pulses - c0, int'(vecs[v].exp_push));
      check("parity_held", o_parity, vecs[v].par);
      check("err_cnt", o_err_cnt, vecs[v].exp_err);
      if (vecs[v].exp_push) pop_check("rx_byte", vecs[v].data);
      else check("no_push_valid", rd_if.o_rd_valid, 0);
    end

    // Start glitch: 3 low cycles must not produce a strobe.
    i_baud_div = 16'd16; i_parity = 2'b10;
    strobes.delete();
    @(negedge i_clk); i_rx_line = 1'b0;
    repeat (3) @(negedge i_clk); i_rx_line = 1'b1;
    repeat (30) @(negedge i_clk);
    check("glitch_strobes", strobes.size(), 0);
    check("glitch_valid", rd_if.o_rd_valid, 0);
    send_frame(8'h55, 16, 16, 2'b10, 1'b0);
    check("post_glitch_strobes", strobes.size(), 10);
    pop_check("post_glitch", 8'h55);

    // Disable after the third strobe.
    c0 = clr_pulses;
    fork
      send_frame(8'hE7, 16, 16, 2'b10, 1'b0);
      begin
        for (int k = 0; k < 300 && strobes.size() < 3; k++) @(negedge i_clk);
        check("abort_reached_3", int'(strobes.size() >= 3), 1);
        i_enable_n = 1'b1;
        @(negedge i_clk);
        check("enable_n_follow", o_enable_n, 1);
      end
    join
    check("abort_strobes", strobes.size(), 3);
    check("abort_valid", rd_if.o_rd_valid, 0);
    check("abort_clr", clr_pulses - c0, 0);
    check("abort_err_cnt", o_err_cnt, 2);
    i_enable_n = 1'b0;
    repeat (4) @(negedge i_clk);
    send_frame(8'h5A, 16, 16, 2'b10, 1'b0);
    check("reenable_strobes", strobes.size(), 10);
    pop_check("reenable", 8'h5A);

    // Reset mid-frame with a byte buffered and parity 01 latched.
    send_frame(8'h11, 16, 16, 2'b10, 1'b0);
    i_baud_div = 16'd16; i_parity = 2'b01;
    strobes.delete();
    @(negedge i_clk); i_rx_line = 1'b0;
    repeat (30) @(negedge i_clk);
    check("pre_rst_strobes", strobes.size(), 2);
    check("pre_rst_valid", rd_if.o_rd_valid, 1);
    check("pre_rst_parity", o_parity, 1);
    check("pre_rst_err_cnt", o_err_cnt, 2);
    i_rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(negedge i_clk); i_rx_line = 1'b1;
    @(negedge i_clk); i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    send_frame(8'hFF, 16, 16, 2'b10, 1'b0);
    check("post_rst_strobes", strobes.size(), 10);
    pop_check("post_rst", 8'hFF);
    check("post_rst_empty", rd_if.o_rd_valid, 0);

    // Overflow: five frames into a four-entry FIFO.
    for (int f = 1; f <= 5; f++) begin
      send_frame(8'(f), 16, 16, 2'b10, 1'b0);
      if (f == 4) check("full_no_ovf", o_ovf, 0);
    end
    check("ovf_set", o_ovf, 1);
    for (int f = 1; f <= 4; f++) pop_check("ovf_pop", f);
    check("ovf_drained", rd_if.o_rd_valid, 0);
    check("ovf_sticky", o_ovf, 1);
    i_clr_stat = 1'b1;
    @(negedge i_clk);
    i_clr_stat = 1'b0;
    check("ovf_cleared", o_ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
